instr_stream_feeder: RTL
========================

# instr_stream_feeder

Synthesizable, parametrised instruction feeder that plays a preloaded program into the core's `icache_instr` input. Software or the bench loads up to DEPTH words, then pulses `start`. The block issues the words in order over a valid/ready handshake and inserts a configurable NOP gap between instructions. It sits between the bench or boot loader and `core`, and replaces hand-timed stimulus with a repeatable, cycle-exact stream.

## Interface
- XLEN, 32, instruction width
- DEPTH, 64, program memory words (≥2)
- GAP, 1, bubble cycles after each accepted instruction (0 = back-to-back)
- NOP_WORD, 32'h00000013, value driven on `instr_out` during gap cycles
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- load_we  in  1  program-memory write strobe
- load_addr  in  $clog2(DEPTH)  write address
- load_data  in  XLEN  write data
- prog_len  in  $clog2(DEPTH)+1  number of words to issue; sampled at `start`
- start  in  1  begin issue from index 0
- stop  in  1  abort the stream
- loop_en  in  1  wrap to index 0 after the last word (macro-gated)
- instr_ready  in  1  consumer accepts `instr_out`
- instr_out  out  XLEN  registered instruction to the core
- instr_valid  out  1  `instr_out` holds a program word
- pc_out  out  $clog2(DEPTH)  index of the word on `instr_out`
- busy  out  1  in ISSUE or GAP
- done  out  1  program completed
- loop_count  out  16  completed passes (macro-gated)

## Operation
- Reset values:
  - state IDLE
  - `instr_out` = 0, `instr_valid` = 0, `pc_out` = 0
  - `busy` = 0, `done` = 0, `loop_count` = 0
  - memory contents are not reset.
- Loading: a write occurs when `load_we` is high and `busy` is low. `load_we` is ignored while `busy` is high.
- `prog_len` is latched at `start`. Values above DEPTH clamp to DEPTH.
- IDLE / DONE with `start`:
  - latched length = 0 → DONE
  - otherwise → ISSUE, with `instr_out` = mem[0], `pc_out` = 0, `done` cleared
- ISSUE: `instr_valid` = 1 and `instr_out` holds stable until `instr_ready`. On handshake:
  - Not the last word: idx+1 is fetched.
    - GAP = 0: next state ISSUE with the next word.
    - GAP > 0: next state GAP, `instr_out` = NOP_WORD, `instr_valid` = 0, gap counter = GAP-1.
  - Last word, no loop: → DONE, `instr_out` = 0, `instr_valid` = 0.
  - Last word, loop: treated as not-last with idx 0; `loop_count` increments, saturating at 16'hFFFF.
- GAP: the counter decrements each cycle. At 0 → ISSUE with the pending word.
- DONE: `done` = 1 and held until the next `start`.
- `stop`, in any state: → IDLE next edge, `instr_valid` = 0, `instr_out` = 0, `done` = 0.
  - `stop` has priority over `start`, handshake and gap expiry.
- `start` while `busy` is ignored.
- A write to the address currently being issued does not occur, because writes are blocked while `busy`.

## Timing
- `start` sampled at edge t → `instr_valid` = 1 from t+1.
- Handshake at edge k → next word valid:
  - GAP = 0: from k+1.
  - otherwise: `instr_valid` low for GAP cycles, then valid from k+GAP+1.
- Throughput with GAP = 0 and `instr_ready` held high: one word per cycle.
- Last handshake at edge k → `done` = 1 from k+1.
- All outputs are registered. There is no combinational path from `instr_ready` to `instr_out` or `instr_valid`.
- Reset assertion mid-stream clears outputs immediately (asynchronous). After deassertion, the block waits in IDLE for `start`.

## Configuration
- `INSTR_FEED_LOOP_EN` defined:
  - `loop_en` is honoured as described in Operation.
  - `loop_count` counts wraps.
  - `loop_en` sampled low at the last handshake ends the stream normally.
- `INSTR_FEED_LOOP_EN` undefined:
  - `loop_en` is ignored.
  - `loop_count` is tied to 0.
  - The stream always ends in DONE after `prog_len` words.

## Test plan
- Load 0x00A00093, 0x01400113, 0x002081B3 at addresses 0–2, with `prog_len` = 3, GAP = 1 and `instr_ready` high. Pulse `start` → `instr_out` sequence is:
  - 0x00A00093 (valid)
  - 0x00000013 (valid low)
  - 0x01400113 (valid)
  - 0x00000013 (valid low)
  - 0x002081B3 (valid)
  - then 0 with `done` = 1 on the following cycle.
- GAP = 0 with `instr_ready` low for 3 cycles on word 1 → `instr_out` is held at 0x01400113 and `pc_out` at 1 for 3 cycles. The word advances on the edge after `instr_ready` rises.
- `prog_len` = 0 with `start` → `done` = 1 next cycle, and `instr_valid` is never asserted.
- Assert `stop` together with a handshake on word 1 of 3 → next cycle IDLE, `instr_valid` = 0, `done` = 0. A `load_we` to address 0 in that cycle is then accepted.
- Assert `rst` asynchronously mid-GAP → `instr_out` = 0, `busy` = 0 before the next edge. A following `start` replays from word 0.
- With `INSTR_FEED_LOOP_EN`, `loop_en` = 1 and `prog_len` = 2 → the word sequence repeats as w0, w1, w0, w1. `loop_count` = 2 after 4 handshakes and `done` stays 0. Without the macro, the same stimulus ends in DONE after 2 words.

Source files
------------

// File: rtl/instr_stream_feeder_if.sv
// Instruction stream handshake between instr_stream_feeder and the core.
// master drives instr_out/instr_valid/pc_out, slave returns instr_ready.
interface instr_stream_feeder_if #(
    parameter int XLEN = 32,
    parameter int AW   = 6
);
    logic [XLEN-1:0] instr_out;
    logic            instr_valid;
    logic [AW-1:0]   pc_out;
    logic            instr_ready;

    modport master (
        output instr_out,
        output instr_valid,
        output pc_out,
        input  instr_ready
    );

    modport slave (
        input  instr_out,
        input  instr_valid,
        input  pc_out,
        output instr_ready
    );
endinterface

// File: rtl/instr_stream_feeder.sv
// Plays a preloaded program into the core over a valid/ready stream,
// inserting GAP NOP cycles after each accepted word.
// Ports: clk, rst (async, active high); load_we/load_addr/load_data fill
// the program memory while idle; prog_len/start/stop control the stream;
// loop_en wraps to word 0; feed (master) carries instr_out, instr_valid,
// pc_out and instr_ready; busy, done and loop_count report status.
// Macro INSTR_FEED_LOOP_EN enables loop_en and loop_count.
module instr_stream_feeder #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 64,
    parameter int              GAP      = 1,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013,
    localparam int             AW       = $clog2(DEPTH),
    localparam int             LW       = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_we,
    input  logic [AW-1:0]         load_addr,
    input  logic [XLEN-1:0]       load_data,
    input  logic [LW-1:0]         prog_len,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    instr_stream_feeder_if.master feed,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           loop_count
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic              done_q, done_d;

    logic [XLEN-1:0]   mem [DEPTH];

    logic [LW-1:0]     len_clamp;
    logic              last;
    logic              wrap;
    logic [AW-1:0]     nxt_idx;

    assign busy = (state_q == S_ISSUE) || (state_q == S_GAP);

    // Writes are blocked while streaming so the issued program is stable.
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    assign len_clamp = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    assign last      = ({1'b0, pc_q} == (len_q - LW'(1)));
    assign nxt_idx   = wrap ? '0 : pc_q + AW'(1);

`ifdef INSTR_FEED_LOOP_EN
    logic [15:0] loop_q, loop_d;

    assign wrap       = last && loop_en;
    assign loop_count = loop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_q <= '0;
        end else begin
            loop_q <= loop_d;
        end
    end

    always_comb begin
        loop_d = loop_q;
        if (!stop && state_q == S_ISSUE && feed.instr_ready &&
            wrap && loop_q != 16'hFFFF) begin
            loop_d = loop_q + 16'd1;
        end
    end
`else
    logic unused_loop_en;

    assign unused_loop_en = loop_en;
    assign wrap           = 1'b0;
    assign loop_count     = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        done_d  = done_q;
        if (stop) begin
            state_d = S_IDLE;
            instr_d = '0;
            valid_d = 1'b0;
            pc_d    = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_d = len_clamp;
                        if (len_clamp == '0) begin
                            state_d = S_DONE;
                            instr_d = '0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                            instr_d = mem[0];
                            valid_d = 1'b1;
                            pc_d    = '0;
                            done_d  = 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (feed.instr_ready) begin
                        if (last && !wrap) begin
                            state_d = S_DONE;
                            instr_d = '0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            // pc_out already points at the pending word
                            // while the gap bubbles are on the bus.
                            pc_d = nxt_idx;
                            if (GAP == 0) begin
                                instr_d = mem[nxt_idx];
                                valid_d = 1'b1;
                            end else begin
                                state_d = S_GAP;
                                instr_d = NOP_WORD;
                                valid_d = 1'b0;
                                gap_d   = GW'(GAP - 1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_ISSUE;
                        instr_d = mem[pc_q];
                        valid_d = 1'b1;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign feed.instr_out   = instr_q;
    assign feed.instr_valid = valid_q;
    assign feed.pc_out      = pc_q;
    assign done             = done_q;

endmodule
